// File: rtl/strobe_decoder_pkg.sv
// Shared types and helpers for the registered strobe decoder.
// Also used by the bench model to build strobe masks.
package strobe_decoder_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} strobe_state_t;

    localparam int MASK_W = 64;

    function automatic logic [MASK_W-1:0] one_cold(input int idx, input int n);
        logic [MASK_W-1:0] m;
        m = '1;
        if (idx >= 0 && idx < n && idx < MASK_W)
            m[idx[5:0]] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/strobe_dwell_counter.sv
// Loadable down-counter that times one strobe.
// Holds at zero; the zero flag ends the strobe.
module strobe_dwell_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= din;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/strobe_decoder.sv
// Registered active-low strobe decoder with dwell timing,
// break-before-make gap and optional auto-scan.
module strobe_decoder
    import strobe_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_N   = 8,
    parameter int DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               N_RST,
    input  logic [SEL_W-1:0]   SEL,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic               REQ,
    input  logic               SCAN,
    input  logic               N_E1,
    input  logic               N_E2,
    input  logic               E3,
    output logic [OUT_N-1:0]   N_Y,
    output logic               BUSY,
    output logic               DONE,
    output logic               ABORT,
    output logic               ERR
);

    localparam logic [SEL_W:0]   OUT_N_L = (SEL_W+1)'(OUT_N);
    localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_N - 1);

    strobe_state_t    state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] nxt_idx;
    logic             aborted;
    logic             en;
    logic             sel_ok;
    logic             can_req;
    logic             start;
    logic             reject;
    logic             scan_go;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    always_comb begin
        en       = !N_E1 && !N_E2 && E3;
        sel_ok   = {1'b0, SEL} < OUT_N_L;
        can_req  = (state == IDLE) && REQ && en;
        start    = can_req && sel_ok;
        reject   = can_req && !sel_ok;
        scan_go  = (state == GAP) && SCAN && en && !aborted;
        nxt_idx  = SEL;
        if (scan_go)
            nxt_idx = (idx == LAST) ? '0 : idx + SEL_W'(1);
        cnt_load = start || scan_go;
        cnt_dec  = (state == ACTIVE) && en && !cnt_zero;
    end

    strobe_dwell_counter #(
        .W (DWELL_W)
    ) u_dwell (
        .clk   (CLK),
        .rst_n (N_RST),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .din   (DWELL),
        .zero  (cnt_zero)
    );

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state   <= IDLE;
            idx     <= '0;
            aborted <= 1'b0;
            N_Y     <= '1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ABORT   <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            ABORT <= 1'b0;
            ERR   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACTIVE;
                        idx   <= nxt_idx;
                        N_Y   <= OUT_N'(one_cold(int'(nxt_idx), OUT_N));
                        BUSY  <= 1'b1;
                    end else if (reject) begin
                        ERR <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Enable loss wins over a normal finish on the same edge
                    if (!en) begin
                        state   <= GAP;
                        N_Y     <= '1;
                        ABORT   <= 1'b1;
                        aborted <= 1'b1;
                    end else if (cnt_zero) begin
                        state   <= GAP;
                        N_Y     <= '1;
                        DONE    <= 1'b1;
                        aborted <= 1'b0;
                    end
                end
                GAP: begin
                    if (scan_go) begin
                        state <= ACTIVE;
                        idx   <= nxt_idx;
                        N_Y   <= OUT_N'(one_cold(int'(nxt_idx), OUT_N));
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    N_Y   <= '1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_decoder.sv
// Bench for strobe_decoder: directed literal checks plus
// randomized traffic against a behavioural strobe model.
module tb_strobe_decoder;
    import strobe_decoder_pkg::*;

    localparam int SEL_W   = 3;
    localparam int OUT_N   = 6;
    localparam int DWELL_W = 4;

    logic               CLK;
    logic               N_RST;
    logic [SEL_W-1:0]   SEL;
    logic [DWELL_W-1:0] DWELL;
    logic               REQ;
    logic               SCAN;
    logic               N_E1;
    logic               N_E2;
    logic               E3;
    logic [OUT_N-1:0]   N_Y;
    logic               BUSY;
    logic               DONE;
    logic               ABORT;
    logic               ERR;

    int n_checks = 0;
    int n_fail   = 0;

    strobe_decoder #(
        .SEL_W   (SEL_W),
        .OUT_N   (OUT_N),
        .DWELL_W (DWELL_W)
    ) dut (
        .CLK   (CLK),
        .N_RST (N_RST),
        .SEL   (SEL),
        .DWELL (DWELL),
        .REQ   (REQ),
        .SCAN  (SCAN),
        .N_E1  (N_E1),
        .N_E2  (N_E2),
        .E3    (E3),
        .N_Y   (N_Y),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ABORT (ABORT),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 strobing, 2 gap.
    // left = strobe cycles still to come after the current one.
    int               m_ph;
    int               m_left;
    int               m_idx;
    bit               m_cut;
    bit               m_en;
    logic [OUT_N-1:0] m_ny;
    bit               m_busy;
    bit               m_done;
    bit               m_abort;
    bit               m_err;

    always @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            m_ph = 0; m_left = 0; m_idx = 0; m_cut = 0;
            m_done = 0; m_abort = 0; m_err = 0;
        end else begin
            m_en = !N_E1 && !N_E2 && E3;
            m_done = 0; m_abort = 0; m_err = 0;
            case (m_ph)
                0: if (REQ && m_en) begin
                    if (int'(SEL) < OUT_N) begin
                        m_ph = 1;
                        m_idx = int'(SEL);
                        m_left = int'(DWELL);
                    end else begin
                        m_err = 1;
                    end
                end
                1: if (!m_en) begin
                    m_ph = 2; m_abort = 1; m_cut = 1;
                end else if (m_left == 0) begin
                    m_ph = 2; m_done = 1; m_cut = 0;
                end else begin
                    m_left--;
                end
                default: if (SCAN && m_en && !m_cut) begin
                    m_ph = 1;
                    m_idx = (m_idx + 1) % OUT_N;
                    m_left = int'(DWELL);
                end else begin
                    m_ph = 0;
                end
            endcase
        end
        m_ny   = (m_ph == 1) ? OUT_N'(one_cold(m_idx, OUT_N)) : '1;
        m_busy = (m_ph != 0);
    end

    always @(negedge CLK) begin
        if (N_RST) begin
            chk("model_ny", 32'(N_Y), 32'(m_ny));
            chk("model_busy", 32'(BUSY), 32'(m_busy));
            chk("model_done", 32'(DONE), 32'(m_done));
            chk("model_abort", 32'(ABORT), 32'(m_abort));
            chk("model_err", 32'(ERR), 32'(m_err));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_idle();
        REQ = 0; SCAN = 0; SEL = '0; DWELL = '0;
        N_E1 = 0; N_E2 = 0; E3 = 1;
    endtask

    logic [OUT_N-1:0] scan_exp [4];

    initial begin
        N_RST = 0;
        set_idle();
        tick(); tick();
        chk("rst_ny", 32'(N_Y), 32'h3F);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_pulses", {29'd0, DONE, ABORT, ERR}, 0);
        N_RST = 1;
        tick(); tick();

        // single strobe SEL=5 DWELL=2
        SEL = 5; DWELL = 2; REQ = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            REQ = 0;
            if (c <= 3) chk("t1_low", 32'(N_Y), 32'h1F);
            if (c == 4) chk("t1_gap", 32'(N_Y), 32'h3F);
            if (c == 4) chk("t1_done", 32'(DONE), 1);
            if (c == 5) chk("t1_idle", 32'(BUSY), 0);
        end
        set_idle(); tick(); tick();

        // abort on E3 loss
        SEL = 3; DWELL = 3; REQ = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            REQ = 0;
            if (c <= 2) chk("t2_low", 32'(N_Y), 32'h37);
            if (c == 2) E3 = 0;
            if (c == 3) begin
                chk("t2_ny", 32'(N_Y), 32'h3F);
                chk("t2_abort", 32'(ABORT), 1);
                chk("t2_done", 32'(DONE), 0);
            end
            if (c == 4) chk("t2_idle", 32'(BUSY), 0);
        end
        set_idle(); tick(); tick();

        // scan with wrap at OUT_N-1
        scan_exp[0] = 6'b101111;
        scan_exp[1] = 6'b011111;
        scan_exp[2] = 6'b111110;
        scan_exp[3] = 6'b111101;
        SCAN = 1; DWELL = 0; SEL = 4; REQ = 1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            REQ = 0;
            if (c <= 7 && c % 2 == 1)
                chk("t3_order", 32'(N_Y), 32'(scan_exp[c/2]));
            if (c % 2 == 0 && c <= 8) begin
                chk("t3_gap", 32'(N_Y), 32'h3F);
                chk("t3_done", 32'(DONE), 1);
            end
            if (c == 7) SCAN = 0;
            if (c == 9) chk("t3_stop", 32'(BUSY), 0);
        end
        set_idle(); tick(); tick();

        // out-of-range select
        SEL = 7; REQ = 1;
        tick();
        REQ = 0;
        chk("t4_err", 32'(ERR), 1);
        chk("t4_ny", 32'(N_Y), 32'h3F);
        chk("t4_busy", 32'(BUSY), 0);
        tick();
        chk("t4_err_pulse", 32'(ERR), 0);
        set_idle(); tick();

        // async reset mid-strobe
        SEL = 0; DWELL = 15; REQ = 1;
        tick();
        REQ = 0;
        chk("t5_low", 32'(N_Y), 32'h3E);
        tick(); tick();
        #2 N_RST = 0;
        #1;
        chk("t5_ny", 32'(N_Y), 32'h3F);
        chk("t5_busy", 32'(BUSY), 0);
        chk("t5_pulses", {30'd0, DONE, ABORT}, 0);
        #1 N_RST = 1;
        set_idle(); tick(); tick();

        // held REQ repeats every DWELL+3 cycles
        SEL = 2; DWELL = 1; REQ = 1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("t6_period", 32'(N_Y),
                (((c - 1) % 4) < 2) ? 32'h3B : 32'h3F);
        end
        set_idle(); tick(); tick(); tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            REQ  = ($urandom % 3) == 0;
            SEL  = SEL_W'($urandom % 8);
            DWELL = (($urandom % 4) == 0) ? DWELL_W'($urandom % 16)
                                          : DWELL_W'($urandom % 3);
            if (($urandom % 20) == 0) SCAN = ~SCAN;
            N_E1 = ($urandom % 30) == 0;
            N_E2 = ($urandom % 30) == 0;
            E3   = ($urandom % 30) != 0;
            if (($urandom % 400) == 0) begin
                #2 N_RST = 0;
                #1 N_RST = 1;
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
